// File: rtl/hwag_delta_angle_sched.sv
// Delta-angle scheduler: one shared restoring divider computes
// dividend[i] / divisor for every enabled channel after each tooth.
// The results are published together at the following tooth.
module hwag_delta_angle_sched #(
  parameter int WIDTH = 24,
  parameter int CH    = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ena,
  input  logic                tooth,
  input  logic [WIDTH-1:0]    divisor,
  input  logic [CH*WIDTH-1:0] dividend,
  input  logic [CH-1:0]       ch_ena,
  output logic [CH*WIDTH-1:0] delta,
  output logic [CH-1:0]       valid,
  output logic                busy,
  output logic                overrun
);

  localparam int CW = (CH > 1) ? $clog2(CH) : 1;
  localparam int BW = $clog2(WIDTH + 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_DIV   = 2'd1;
  localparam logic [1:0] S_STORE = 2'd2;

  logic [1:0]                  state_reg;
  logic [WIDTH-1:0]            snap_divisor_reg;
  logic [CH-1:0][WIDTH-1:0]    snap_dividend_reg;
  logic [CH-1:0]               snap_ch_ena_reg;
  logic [CW-1:0]               cur_ch_reg;
  logic [BW-1:0]               bit_cnt_reg;
  logic [WIDTH:0]              rem_reg;
  logic [WIDTH-1:0]            quo_reg;
  logic [WIDTH-1:0]            dvd_reg;
  logic [CH-1:0][WIDTH-1:0]    pending_reg;
  logic [CH-1:0]               done_reg;
  logic [CH-1:0][WIDTH-1:0]    delta_reg;
  logic [CH-1:0]               valid_reg;
  logic                        overrun_reg;

  logic [CH-1:0][WIDTH-1:0]    dividend_arr;
  logic                        first_any;
  logic [CW-1:0]               first_idx;
  logic                        has_next;
  logic [CW-1:0]               next_idx;
  logic [WIDTH:0]              rem_shift;
  logic                        rem_ge;
  logic [WIDTH:0]              rem_step;
  logic [WIDTH-1:0]            quo_step;
  logic [CH-1:0][WIDTH-1:0]    pending_fin;
  logic [CH-1:0]               done_fin;
  logic                        last_store;
  logic                        tooth_accept;
  logic                        tooth_abort;

  assign dividend_arr = dividend;

  // Channel selection: lowest enabled input channel, and next higher snapshot channel
  always_comb begin
    first_any = 1'b0;
    first_idx = '0;
    has_next  = 1'b0;
    next_idx  = '0;
    for (int i = CH - 1; i >= 0; i--) begin
      if (ch_ena[i]) begin
        first_any = 1'b1;
        first_idx = CW'(i);
      end
      if (snap_ch_ena_reg[i] && (i > int'(cur_ch_reg))) begin
        has_next = 1'b1;
        next_idx = CW'(i);
      end
    end
  end

  // One restoring-division step; a zero divisor naturally yields all ones
  always_comb begin
    rem_shift = {rem_reg[WIDTH-1:0], dvd_reg[WIDTH-1]};
    rem_ge    = (rem_shift >= {1'b0, snap_divisor_reg});
    rem_step  = rem_ge ? (rem_shift - {1'b0, snap_divisor_reg}) : rem_shift;
    quo_step  = {quo_reg[WIDTH-2:0], rem_ge};
  end

  // Results as they stand including a quotient being stored this cycle
  always_comb begin
    pending_fin = pending_reg;
    done_fin    = done_reg;
    if (state_reg == S_STORE) begin
      pending_fin[cur_ch_reg] = quo_reg;
      done_fin[cur_ch_reg]    = 1'b1;
    end
  end

  // A tooth on the last STORE completes the sequence rather than aborting it
  assign last_store   = (state_reg == S_STORE) && !has_next;
  assign tooth_accept = ena && tooth && ((state_reg == S_IDLE) || last_store);
  assign tooth_abort  = ena && tooth && !((state_reg == S_IDLE) || last_store);

  // Sequencer and shared divider datapath
  always_ff @(posedge clk) begin
    if (rst || !ena) begin
      state_reg         <= S_IDLE;
      snap_divisor_reg  <= '0;
      snap_dividend_reg <= '0;
      snap_ch_ena_reg   <= '0;
      cur_ch_reg        <= '0;
      bit_cnt_reg       <= '0;
      rem_reg           <= '0;
      quo_reg           <= '0;
      dvd_reg           <= '0;
      pending_reg       <= '0;
      done_reg          <= '0;
    end else if (tooth) begin
      // Any tooth (accepted or overrun) takes a fresh snapshot and restarts
      snap_divisor_reg  <= divisor;
      snap_dividend_reg <= dividend_arr;
      snap_ch_ena_reg   <= ch_ena;
      pending_reg       <= '0;
      done_reg          <= '0;
      cur_ch_reg        <= first_idx;
      bit_cnt_reg       <= '0;
      rem_reg           <= '0;
      quo_reg           <= '0;
      dvd_reg           <= dividend_arr[first_idx];
      state_reg         <= first_any ? S_DIV : S_IDLE;
    end else begin
      case (state_reg)
        S_IDLE: begin
        end
        S_DIV: begin
          rem_reg     <= rem_step;
          quo_reg     <= quo_step;
          dvd_reg     <= {dvd_reg[WIDTH-2:0], 1'b0};
          bit_cnt_reg <= bit_cnt_reg + 1'b1;
          if (bit_cnt_reg == BW'(WIDTH - 1)) begin
            state_reg <= S_STORE;
          end
        end
        S_STORE: begin
          pending_reg <= pending_fin;
          done_reg    <= done_fin;
          if (has_next) begin
            cur_ch_reg  <= next_idx;
            bit_cnt_reg <= '0;
            rem_reg     <= '0;
            quo_reg     <= '0;
            dvd_reg     <= snap_dividend_reg[next_idx];
            state_reg   <= S_DIV;
          end else begin
            state_reg <= S_IDLE;
          end
        end
        default: state_reg <= S_IDLE;
      endcase
    end
  end

  // Published outputs: change only on an accepted tooth or clear
  always_ff @(posedge clk) begin
    if (rst || !ena) begin
      delta_reg   <= '0;
      valid_reg   <= '0;
      overrun_reg <= 1'b0;
    end else begin
      overrun_reg <= tooth_abort;
      if (tooth_accept) begin
        delta_reg <= pending_fin;
        valid_reg <= done_fin;
      end
    end
  end

  assign delta   = delta_reg;
  assign valid   = valid_reg;
  assign overrun = overrun_reg;
  assign busy    = (state_reg != S_IDLE);

endmodule

// File: tb/tb_hwag_delta_angle_sched.sv
// Self-checking bench for hwag_delta_angle_sched. The reference model works
// per tooth: a sequence of k enabled channels lasts k*(W+1) cycles; a tooth
// arriving at least that many cycles after the previous one publishes its
// quotients, an earlier one is an overrun.
module tb_hwag_delta_angle_sched;
  localparam int W  = 24;
  localparam int CH = 4;

  logic            clk = 1'b0;
  logic            rst, ena, tooth;
  logic [W-1:0]    divisor;
  logic [CH*W-1:0] dividend;
  logic [CH-1:0]   ch_ena;
  logic [CH*W-1:0] delta;
  logic [CH-1:0]   valid;
  logic            busy, overrun;

  hwag_delta_angle_sched #(.WIDTH(W), .CH(CH)) dut (
    .clk(clk), .rst(rst), .ena(ena), .tooth(tooth), .divisor(divisor),
    .dividend(dividend), .ch_ena(ch_ena), .delta(delta), .valid(valid),
    .busy(busy), .overrun(overrun)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // reference model state
  int            m_len;
  int            m_gap;
  logic [CH-1:0] m_mask;
  logic [W-1:0]  m_vals [CH];
  logic [W-1:0]  exp_delta [CH];
  logic [CH-1:0] exp_valid;
  logic          exp_ovr;
  logic          obs_ovr;
  int            busy_cnt, ovr_cnt, prev_busy_cnt, prev_busy_exp, prev_ovr_cnt;
  bit            scramble = 0;

  function automatic logic [W-1:0] ref_quot(input logic [W-1:0] dd, input logic [W-1:0] dv);
    if (dv == 0) return {W{1'b1}};
    return dd / dv;
  endfunction

  function automatic logic [W-1:0] ch_of(input logic [CH*W-1:0] v, input int i);
    return v[i*W +: W];
  endfunction

  task automatic model_clear();
    m_len = 0; m_gap = 0; m_mask = '0; exp_valid = '0; exp_ovr = 0;
    busy_cnt = 0; ovr_cnt = 0;
    for (int i = 0; i < CH; i++) begin m_vals[i] = '0; exp_delta[i] = '0; end
  endtask

  task automatic tick();
    @(posedge clk); #1;
    m_gap++;
    if (busy) busy_cnt++;
    if (overrun) ovr_cnt++;
    if (scramble) begin
      divisor  = W'($urandom);
      dividend = {$urandom, $urandom, $urandom};
      ch_ena   = CH'($urandom);
    end
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  // Drive one tooth with the given inputs and advance the model
  task automatic pulse(input logic [W-1:0] dv, input logic [CH*W-1:0] dd, input logic [CH-1:0] ce);
    int n;
    prev_busy_exp = (m_gap < m_len) ? m_gap : m_len;
    prev_busy_cnt = busy_cnt;
    prev_ovr_cnt  = ovr_cnt;
    if (m_len > 0 && m_gap < m_len) begin
      exp_ovr = 1;
    end else begin
      exp_ovr = 0;
      exp_valid = m_mask;
      for (int i = 0; i < CH; i++) exp_delta[i] = m_vals[i];
    end
    n = 0;
    m_mask = ce;
    for (int i = 0; i < CH; i++) begin
      m_vals[i] = ce[i] ? ref_quot(ch_of(dd, i), dv) : '0;
      if (ce[i]) n++;
    end
    m_len = n * (W + 1);
    divisor = dv; dividend = dd; ch_ena = ce; tooth = 1;
    @(posedge clk); #1;
    tooth = 0;
    obs_ovr  = overrun;
    busy_cnt = busy ? 1 : 0;
    ovr_cnt  = 0;
    m_gap    = 1;
  endtask

  task automatic test_reset();
    rst = 1; ena = 1; tooth = 0; divisor = '0; dividend = '0; ch_ena = '0;
    repeat (3) @(posedge clk);
    #1;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
    total++; if (overrun !== 1'b0) begin bad++; $display("FAIL reset_overrun got=%b want=0", overrun); end
    total++; if (valid !== '0) begin bad++; $display("FAIL reset_valid got=%b want=0", valid); end
    total++; if (delta !== '0) begin bad++; $display("FAIL reset_delta got=%h want=0", delta); end
    rst = 0;
    model_clear();
    tick();
    $display("test_reset done");
  endtask

  task automatic test_single();
    logic [CH*W-1:0] dd;
    dd = '0; dd[0 +: W] = 24'd1000;
    pulse(24'd10, dd, 4'b0001);
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL single_busy_start got=%b want=1", busy); end
    ticks(34);
    total++; if (ch_of(delta, 0) !== '0) begin bad++; $display("FAIL single_early_delta got=%0d want=0", ch_of(delta, 0)); end
    pulse(24'd10, dd, 4'b0001);
    total++; if (prev_busy_cnt != 25) begin bad++; $display("FAIL single_busy_len got=%0d want=25", prev_busy_cnt); end
    total++; if (ch_of(delta, 0) !== 24'd100 || ch_of(delta, 0) !== exp_delta[0]) begin bad++; $display("FAIL single_delta0 got=%0d want=100", ch_of(delta, 0)); end
    total++; if (valid !== 4'b0001) begin bad++; $display("FAIL single_valid got=%b want=0001", valid); end
    total++; if (obs_ovr !== 1'b0) begin bad++; $display("FAIL single_ovr got=%b want=0", obs_ovr); end
    $display("test_single: delta0=%0d valid=%b", ch_of(delta, 0), valid);
  endtask

  task automatic test_four();
    logic [CH*W-1:0] dd;
    dd = {24'd7, 24'hFFFFFF, 24'd1000, 24'd511};
    ticks(40);
    pulse(24'd3, dd, 4'b1111);
    ticks(199);
    pulse(24'd3, dd, 4'b1111);
    total++; if (prev_busy_cnt != 100) begin bad++; $display("FAIL four_busy_len got=%0d want=100", prev_busy_cnt); end
    total++; if (valid !== 4'b1111) begin bad++; $display("FAIL four_valid got=%b want=1111", valid); end
    for (int i = 0; i < CH; i++) begin
      total++; if (ch_of(delta, i) !== exp_delta[i]) begin bad++; $display("FAIL four_delta%0d got=%0d want=%0d", i, ch_of(delta, i), exp_delta[i]); end
    end
    $display("test_four: delta=%0d/%0d/%0d/%0d", ch_of(delta, 0), ch_of(delta, 1), ch_of(delta, 2), ch_of(delta, 3));
  endtask

  task automatic test_overrun();
    logic [CH*W-1:0] dd;
    logic [CH-1:0]   v_before;
    logic [CH*W-1:0] d_before;
    dd = {24'd30, 24'd300, 24'd600, 24'd900};
    ticks(49);
    v_before = valid; d_before = delta;
    pulse(24'd3, dd, 4'b1111);
    total++; if (obs_ovr !== 1'b1 || exp_ovr !== 1'b1) begin bad++; $display("FAIL ovr_pulse got=%b want=1", obs_ovr); end
    total++; if (valid !== v_before || delta !== d_before) begin bad++; $display("FAIL ovr_hold got=%b/%h want=%b/%h", valid, delta, v_before, d_before); end
    ticks(149);
    pulse(24'd3, dd, 4'b1111);
    total++; if (prev_ovr_cnt != 0) begin bad++; $display("FAIL ovr_width got=%0d extra cycles want=0", prev_ovr_cnt); end
    total++; if (prev_busy_cnt != 100) begin bad++; $display("FAIL ovr_busy_len got=%0d want=100", prev_busy_cnt); end
    for (int i = 0; i < CH; i++) begin
      total++; if (ch_of(delta, i) !== exp_delta[i]) begin bad++; $display("FAIL ovr_delta%0d got=%0d want=%0d", i, ch_of(delta, i), exp_delta[i]); end
    end
    $display("test_overrun: valid=%b", valid);
  endtask

  task automatic test_div_zero();
    logic [CH*W-1:0] dd;
    dd = '0; dd[W +: W] = 24'd5;
    ticks(120);
    pulse(24'd0, dd, 4'b0010);
    ticks(29);
    pulse(24'd0, dd, 4'b0010);
    total++; if (ch_of(delta, 1) !== 24'hFFFFFF) begin bad++; $display("FAIL divzero_delta1 got=%h want=ffffff", ch_of(delta, 1)); end
    total++; if (valid !== 4'b0010) begin bad++; $display("FAIL divzero_valid got=%b want=0010", valid); end
    total++; if (prev_busy_cnt != 25) begin bad++; $display("FAIL divzero_busy got=%0d want=25", prev_busy_cnt); end
    $display("test_div_zero: delta1=%h", ch_of(delta, 1));
  endtask

  task automatic test_back_to_back();
    logic [CH*W-1:0] dd;
    ticks(30);
    dd = '0; dd[0 +: W] = 24'd777;
    pulse(24'd10, dd, 4'b0001);
    ticks(24);
    dd[0 +: W] = 24'd50;
    pulse(24'd10, dd, 4'b0001);
    total++; if (obs_ovr !== 1'b0) begin bad++; $display("FAIL b2b_ovr got=%b want=0", obs_ovr); end
    total++; if (ch_of(delta, 0) !== 24'd77) begin bad++; $display("FAIL b2b_delta0 got=%0d want=77", ch_of(delta, 0)); end
    total++; if (valid !== 4'b0001) begin bad++; $display("FAIL b2b_valid got=%b want=0001", valid); end
    ticks(29);
    pulse(24'd10, dd, 4'b0001);
    total++; if (prev_busy_cnt != 25) begin bad++; $display("FAIL b2b_busy got=%0d want=25", prev_busy_cnt); end
    total++; if (ch_of(delta, 0) !== 24'd5) begin bad++; $display("FAIL b2b_delta0_second got=%0d want=5", ch_of(delta, 0)); end
    $display("test_back_to_back: delta0=%0d", ch_of(delta, 0));
  endtask

  task automatic test_clear();
    ticks(30);
    pulse(24'd3, {24'd9, 24'd8, 24'd7, 24'd6}, 4'b1111);
    ticks(10);
    ena = 0;
    tick();
    total++; if (busy !== 1'b0 || valid !== '0 || delta !== '0) begin bad++; $display("FAIL ena_clear got busy=%b valid=%b delta=%h want 0/0/0", busy, valid, delta); end
    busy_cnt = 0; ovr_cnt = 0;
    tooth = 1; tick(); tooth = 0;
    ticks(5);
    total++; if (busy_cnt != 0 || ovr_cnt != 0) begin bad++; $display("FAIL ena_tooth_ignored got busy=%0d ovr=%0d want 0/0", busy_cnt, ovr_cnt); end
    ena = 1;
    model_clear();
    tick();
    pulse(24'd3, {24'd9, 24'd8, 24'd7, 24'd6}, 4'b1111);
    ticks(120);
    pulse(24'd3, {24'd9, 24'd8, 24'd7, 24'd6}, 4'b1111);
    ticks(10);
    total++; if (valid !== 4'b1111) begin bad++; $display("FAIL clear_precheck got=%b want=1111", valid); end
    rst = 1;
    tick();
    rst = 0;
    total++; if (busy !== 1'b0 || valid !== '0 || delta !== '0) begin bad++; $display("FAIL rst_clear got busy=%b valid=%b delta=%h want 0/0/0", busy, valid, delta); end
    model_clear();
    $display("test_clear done");
  endtask

  task automatic test_random();
    logic [W-1:0]    dv;
    logic [CH*W-1:0] dd;
    logic [CH-1:0]   ce;
    int              gap;
    scramble = 1;
    for (int it = 0; it < 40; it++) begin
      case ($urandom_range(0, 3))
        0: dv = '0;
        1: dv = W'($urandom_range(1, 20));
        default: dv = W'($urandom >> $urandom_range(8, 31));
      endcase
      for (int i = 0; i < CH; i++) dd[i*W +: W] = W'($urandom >> $urandom_range(0, 16));
      ce = CH'($urandom);
      if (m_len > 0 && $urandom_range(0, 3) == 0) gap = m_len;
      else gap = $urandom_range(1, 120);
      if (gap > m_gap) ticks(gap - m_gap);
      pulse(dv, dd, ce);
      total++; if (obs_ovr !== exp_ovr) begin bad++; $display("FAIL rnd%0d_ovr got=%b want=%b", it, obs_ovr, exp_ovr); end
      total++; if (prev_busy_cnt != prev_busy_exp) begin bad++; $display("FAIL rnd%0d_busy got=%0d want=%0d", it, prev_busy_cnt, prev_busy_exp); end
      total++; if (prev_ovr_cnt != 0) begin bad++; $display("FAIL rnd%0d_ovr_extra got=%0d want=0", it, prev_ovr_cnt); end
      total++; if (valid !== exp_valid) begin bad++; $display("FAIL rnd%0d_valid got=%b want=%b", it, valid, exp_valid); end
      for (int i = 0; i < CH; i++) begin
        total++; if (ch_of(delta, i) !== exp_delta[i]) begin bad++; $display("FAIL rnd%0d_delta%0d got=%0d want=%0d", it, i, ch_of(delta, i), exp_delta[i]); end
      end
      $display("rnd %0d: gap=%0d ce=%b dv=%0d ovr=%b valid=%b", it, gap, ce, dv, obs_ovr, valid);
    end
    scramble = 0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_four();
    test_overrun();
    test_div_zero();
    test_back_to_back();
    test_clear();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout got=running want=finished");
    $fatal(1, "timeout");
  end
endmodule
